// File: rtl/uart_tx_drain.sv
// UART transmitter that drains a registered-output byte FIFO onto a serial TX line (8N1/8N2, LSB first).
// Optional even-parity bit between data and stop is compiled in with `define UART_TX_PARITY_EN.
module uart_tx_drain #(
  parameter int CLKS_PER_BIT = 104,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] fifo_data,
  input  logic       fifo_available,
  output logic       fifo_get,
  output logic       tx,
  output logic       busy
);

  localparam int                CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]     CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP} state_t;
`endif

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shreg;
`ifdef UART_TX_PARITY_EN
  logic          r_parity;
`endif

  wire w_bit_done = (r_cnt == CNT_LAST);

  // NOTE: every register here, datapath included, is cleared by the async reset so tx and the
  // shifter start from a known state; all state updates use non-blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shreg   <= '0;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
      fifo_get  <= 1'b0;
      tx        <= 1'b1;
      busy      <= 1'b0;
    end else begin
      fifo_get <= 1'b0;
      case (r_state)
        IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          if (enable && fifo_available) begin
            r_state  <= FETCH;
            r_cnt    <= '0;
            fifo_get <= 1'b1;
            busy     <= 1'b1;
          end
        end

        // fifo_get is high during this cycle; the FIFO still presents the current byte.
        FETCH: begin
          r_shreg <= fifo_data;
`ifdef UART_TX_PARITY_EN
          r_parity <= ^fifo_data;
`endif
          tx      <= 1'b0;
          r_cnt   <= '0;
          r_state <= START;
        end

        START: begin
          if (w_bit_done) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            tx        <= r_shreg[0];
            r_state   <= DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        DATA: begin
          if (w_bit_done) begin
            r_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              tx      <= r_parity;
              r_state <= PARITY;
`else
              tx      <= 1'b1;
              r_state <= STOP;
`endif
            end else begin
              r_shreg   <= {1'b0, r_shreg[7:1]};
              tx        <= r_shreg[1];
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (w_bit_done) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            tx        <= 1'b1;
            r_state   <= STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif

        // r_bit_idx counts stop bits here so STOP_BITS=2 needs no wider baud counter.
        STOP: begin
          if (w_bit_done) begin
            r_cnt <= '0;
            if (r_bit_idx == STOP_LAST) begin
              r_bit_idx <= '0;
              busy      <= 1'b0;
              r_state   <= IDLE;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= IDLE;
          tx      <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Directed bench for uart_tx_drain (CLKS_PER_BIT=4) with a behavioural FIFO and a byte scoreboard.
// Build with +define+UART_TX_PARITY_EN to cover the parity frame variant.
module tb_uart_tx_drain;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int GAP = NB * CPB + 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_available = 1'b0;
  logic       fifo_get;
  logic       tx;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] sb[$];

  uart_tx_drain #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_data(fifo_data),
    .fifo_available(fifo_available), .fifo_get(fifo_get), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: registered out, available reflects occupancy before this edge's get (one cycle stale).
  always @(posedge clk) begin
    int occ;
    occ = fifo_q.size();
    if (fifo_get && occ > 0) void'(fifo_q.pop_front());
    fifo_available <= (occ > 0);
    fifo_data      <= (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    sb.push_back(b);
  endtask

  // Waits (bounded) for the FETCH pulse, then checks every cycle of the frame against the scoreboard byte.
  task automatic recv_frame(input int max_wait, output int get_cyc);
    logic [7:0]    exp_byte;
    logic [7:0]    got;
    logic [NB-1:0] fr;
    int n;
    n = 0;
    while (fifo_get !== 1'b1 && n < max_wait) begin
      @(negedge clk);
      n++;
    end
    check("get_seen", fifo_get, 1);
    get_cyc  = cyc;
    exp_byte = 8'h00;
    if (sb.size() > 0) exp_byte = sb.pop_front();
    check("busy_fetch", busy, 1);
    fr      = '1;
    fr[0]   = 1'b0;
    fr[8:1] = exp_byte;
`ifdef UART_TX_PARITY_EN
    fr[9]   = ^exp_byte;
`endif
    got = 8'h00;
    for (int b = 0; b < NB; b++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        check($sformatf("tx_bit%0d_c%0d", b, c), tx, fr[b]);
        check("get_in_frame", fifo_get, 0);
        check("busy_in_frame", busy, 1);
        if (c == CPB / 2 && b >= 1 && b <= 8) got[b-1] = tx;
      end
    end
    check("byte_decoded", got, exp_byte);
    @(negedge clk);
    check("busy_idle", busy, 0);
    check("tx_idle", tx, 1);
  endtask

  task automatic watch_idle(input string tag, input int cycles);
    int gets, lows;
    gets = 0;
    lows = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (fifo_get !== 1'b0) gets++;
      if (tx !== 1'b1) lows++;
    end
    check({tag, "_gets"}, gets, 0);
    check({tag, "_tx_low"}, lows, 0);
  endtask

  initial begin
    int g0, g1, g2, n;

    // Reset with data waiting: outputs must be quiet.
    enable = 1'b1;
    push_byte(8'hA5);
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_get", fifo_get, 0);
    check("rst_busy", busy, 0);

    // Release mid-cycle; FETCH is the next full cycle (the 2nd cycle counting the release cycle).
    rst_n = 1'b1;
    @(negedge clk);
    check("fetch_after_reset", fifo_get, 1);
    recv_frame(0, g0);
    watch_idle("empty", 20);

    // Back-to-back frames with exact get spacing.
    push_byte(8'h00);
    push_byte(8'hFF);
    push_byte(8'h55);
    recv_frame(10, g0);
    recv_frame(GAP + 5, g1);
    recv_frame(GAP + 5, g2);
    check("gap_01", g1 - g0, GAP);
    check("gap_12", g2 - g1, GAP);
    watch_idle("drained", 60);

    // Drop enable during data bit 3 of the first of two queued bytes.
    push_byte(8'h3C);
    push_byte(8'h5A);
    fork
      recv_frame(10, g0);
      begin
        for (int i = 0; i < 10 && fifo_get !== 1'b1; i++) @(negedge clk);
        repeat (CPB + 3 * CPB + 2) @(negedge clk);
        enable = 1'b0;
      end
    join
    watch_idle("disabled", 60);
    enable = 1'b1;
    recv_frame(10, g0);
    watch_idle("reenabled", 20);

    // Async reset during data bit 5; the interrupted byte is dropped from the scoreboard.
    push_byte(8'h00);
    push_byte(8'h81);
    n = 0;
    while (fifo_get !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("get_before_midreset", fifo_get, 1);
    if (sb.size() > 0) void'(sb.pop_front());
    repeat (CPB + 5 * CPB + 2) @(negedge clk);
    check("tx_bit5_before_reset", tx, 0);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_tx_async", tx, 1);
    check("midreset_busy", busy, 0);
    check("midreset_get", fifo_get, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("fetch_after_midreset", fifo_get, 1);
    recv_frame(0, g0);
    watch_idle("after_midreset", 60);

`ifdef UART_TX_PARITY_EN
    // Parity frames: 0x07 has odd weight (parity 1), 0x03 even weight (parity 0).
    push_byte(8'h07);
    push_byte(8'h03);
    recv_frame(10, g0);
    recv_frame(GAP + 5, g1);
    check("parity_gap", g1 - g0, GAP);
    watch_idle("parity_drained", 20);
`endif

    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
